// File: rtl/pcm_mixer.sv
// Mixes N_CH unsigned PCM channels with per-channel 4-bit gain and mute, one channel every CALC_CNT
// cycles. Define PCM_MIXER_SAT_EN to saturate the output and track a clip flag instead of wrapping.
module pcm_mixer #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned OUT_W    = 12,
    parameter int unsigned CALC_CNT = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   valid,
    output logic                   ready,
    input  logic [3:0]             wstrb,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    input  logic [N_CH*IN_W-1:0]   ch,
    output logic [OUT_W-1:0]       out,
    output logic                   out_valid
);

    localparam int unsigned ACC_W  = IN_W + 4 + $clog2(N_CH);
    localparam int unsigned WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [3:0]       CNT_LAST = 4'(CALC_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);
    localparam logic [5:0]       REG_CTRL   = 6'd32;
    localparam logic [5:0]       REG_STATUS = 6'd33;

    logic [4:0]        vol [N_CH];
    logic              en;
    logic [15:0]       frame_cnt;
    logic              clip;
    logic [1:0]        state;
    logic [IDX_W-1:0]  ch_idx;
    logic [3:0]        cnt;
    logic [ACC_W-1:0]  acc;

    logic [5:0]        reg_idx;
    logic              wr_en;
    logic [31:0]       rd_val;
    logic [IN_W-1:0]   cur_sample;
    logic [4:0]        cur_vol;
    logic [IN_W+3:0]   product;
    logic [ACC_W-1:0]  term;
    logic [WIDE_W-1:0] acc_wide;
    logic [OUT_W-1:0]  fit_val;
    logic              unused_bits;

    assign reg_idx = addr[7:2];
    assign wr_en   = valid && wstrb[0];
    assign unused_bits = ^{addr[31:8], addr[1:0], wstrb[3:1], wdata[31:5]};

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (reg_idx == 6'(k)) rd_val = {27'd0, vol[k]};
        end
        if (reg_idx == REG_CTRL)   rd_val = {31'd0, en};
        if (reg_idx == REG_STATUS) rd_val = {15'd0, clip, frame_cnt};
    end

    always_comb begin
        cur_sample = '0;
        cur_vol    = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (ch_idx == IDX_W'(k)) begin
                cur_sample = ch[k*IN_W +: IN_W];
                cur_vol    = vol[k];
            end
        end
    end

    assign product  = {4'd0, cur_sample} * {{IN_W{1'b0}}, cur_vol[3:0]};
    assign term     = cur_vol[4] ? '0 : ACC_W'(product);
    assign acc_wide = WIDE_W'(acc);

`ifdef PCM_MIXER_SAT_EN
    localparam logic [WIDE_W-1:0] OUT_MAX = WIDE_W'((64'd1 << OUT_W) - 64'd1);
    logic over;

    assign over    = acc_wide > OUT_MAX;
    assign fit_val = over ? OUT_MAX[OUT_W-1:0] : acc_wide[OUT_W-1:0];

    // A clip event in the same cycle as a W1C write wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clip <= 1'b0;
        end else if (state == S_OUT && over) begin
            clip <= 1'b1;
        end else if (wr_en && reg_idx == REG_STATUS && wdata[16]) begin
            clip <= 1'b0;
        end
    end
`else
    assign fit_val = acc_wide[OUT_W-1:0];
    assign clip    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready <= 1'b0;
            rdata <= '0;
            en    <= 1'b0;
            for (int k = 0; k < int'(N_CH); k++) vol[k] <= '0;
        end else begin
            ready <= valid;
            if (valid) rdata <= rd_val;
            if (wr_en) begin
                for (int k = 0; k < int'(N_CH); k++) begin
                    if (reg_idx == 6'(k)) vol[k] <= wdata[4:0];
                end
                if (reg_idx == REG_CTRL) en <= wdata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            ch_idx    <= '0;
            cnt       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state  <= S_ADD;
                        ch_idx <= '0;
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                S_ADD: begin
                    if (!en) begin
                        // Abort: partial sum is dropped, out keeps its last value.
                        state  <= S_IDLE;
                        ch_idx <= '0;
                        cnt    <= '0;
                        acc    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        acc <= acc + term;
                        cnt <= '0;
                        if (ch_idx == IDX_LAST) begin
                            state <= S_OUT;
                        end else begin
                            ch_idx <= ch_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_OUT: begin
                    out       <= fit_val;
                    out_valid <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    acc       <= '0;
                    ch_idx    <= '0;
                    cnt       <= '0;
                    state     <= en ? S_ADD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_mixer.sv
// Randomized scoreboard bench for pcm_mixer: expected mix results and their arrival cycles are
// queued by the stimulus side and checked by an independent output monitor.
module tb_pcm_mixer;

    localparam int N_CH     = 4;
    localparam int IN_W     = 8;
    localparam int OUT_W    = 12;
    localparam int CALC_CNT = 2;
    localparam int FRAME    = N_CH * CALC_CNT + 1;
    localparam int OUT_MAX  = (1 << OUT_W) - 1;
    localparam logic [31:0] A_CTRL   = 32'd128;
    localparam logic [31:0] A_STATUS = 32'd132;

    logic                  clk;
    logic                  resetn;
    logic                  valid;
    logic                  ready;
    logic [3:0]            wstrb;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic [N_CH*IN_W-1:0]  ch;
    logic [OUT_W-1:0]      out;
    logic                  out_valid;

    pcm_mixer #(
        .N_CH     (N_CH),
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .CALC_CNT (CALC_CNT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .ready     (ready),
        .wstrb     (wstrb),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ch        (ch),
        .out       (out),
        .out_valid (out_valid)
    );

    typedef struct {
        int unsigned value;
        int unsigned cycle;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    logic [IN_W-1:0] m_ch  [N_CH];
    logic [4:0]      m_vol [N_CH];
    logic            m_en;
    int unsigned     m_fcnt;
    bit              m_clip;
    int unsigned     m_last_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor: every out_valid pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out=0x%0h, expected no pulse (cycle %0d)",
                             out, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("mix_out", 32'(out), e.value);
                    check("out_valid_cycle", cyc, e.cycle);
                end
            end
        end
    end

    function automatic int unsigned mix_sum();
        int unsigned s = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (!m_vol[k][4]) s += int'(m_ch[k]) * int'(m_vol[k][3:0]);
        end
        return s;
    endfunction

    function automatic int unsigned fit(input int unsigned s);
`ifdef PCM_MIXER_SAT_EN
        return (s > OUT_MAX) ? OUT_MAX : s;
`else
        return s % (OUT_MAX + 1);
`endif
    endfunction

    task automatic drive_ch();
        for (int k = 0; k < N_CH; k++) ch[k*IN_W +: IN_W] = m_ch[k];
    endtask

    // Bus tasks start and end #1 after a rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1;
        wstrb = 4'h1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        valid = 1'b1;
        wstrb = 4'h0;
        addr  = a;
        @(posedge clk);
        #1;
        d = rdata;
        check("ready_ack", 32'(ready), 32'd1);
        valid = 1'b0;
    endtask

    task automatic set_vol(input int k, input logic [4:0] v);
        bus_write(32'(k * 4), {27'd0, v});
        m_vol[k] = v;
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        bus_read(A_STATUS, d);
        check(name, d, (32'(m_clip) << 16) | (m_fcnt & 32'hFFFF));
    endtask

    // Enable, let `frames` complete, then drop EN j cycles into the following frame.
    task automatic run_epoch(input int frames, input int j);
        int unsigned e0;
        int unsigned v;
        exp_t        e;
        v = fit(mix_sum());
        bus_write(A_CTRL, 32'd1);
        m_en = 1'b1;
        e0 = cyc;
        for (int f = 1; f <= frames; f++) begin
            e.value = v;
            e.cycle = e0 + 32'(FRAME * f + 1);
            sb_q.push_back(e);
        end
        repeat (FRAME * frames + j) @(posedge clk);
        #1;
        bus_write(A_CTRL, 32'd0);
        m_en = 1'b0;
        repeat (FRAME + 2) @(posedge clk);
        #1;
        if (frames > 0) begin
            m_last_out = v;
`ifdef PCM_MIXER_SAT_EN
            if (mix_sum() > OUT_MAX) m_clip = 1'b1;
`endif
        end
        m_fcnt = (m_fcnt + frames) & 32'hFFFF;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("out_hold", 32'(out), m_last_out);
        check("out_valid_idle", 32'(out_valid), 32'd0);
        check_status("status_after_epoch");
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) m_vol[k] = '0;
        m_en       = 1'b0;
        m_fcnt     = 0;
        m_clip     = 1'b0;
        m_last_out = 0;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] d;
        int          k;

        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        addr   = '0;
        wdata  = '0;
        for (int i = 0; i < N_CH; i++) m_ch[i] = '0;
        drive_ch();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_status("reset_status");
        bus_read(32'd0, d);
        check("reset_vol0", d, 32'd0);

        // Basic mix: only ch0 audible.
        for (int i = 0; i < N_CH; i++) m_ch[i] = IN_W'($urandom);
        m_ch[0] = 8'h10;
        drive_ch();
        set_vol(0, 5'd3);
        for (int i = 1; i < N_CH; i++) set_vol(i, 5'd0);
        run_epoch(3, 2);
        check("basic_out", 32'(out), 32'h030);

        // Overload: full scale everywhere.
        for (int i = 0; i < N_CH; i++) begin
            m_ch[i] = 8'hFF;
            set_vol(i, 5'd15);
        end
        drive_ch();
        run_epoch(1, 0);
`ifdef PCM_MIXER_SAT_EN
        check("overload_out", 32'(out), 32'd4095);
`else
        check("overload_out", 32'(out), 32'd3012);
`endif
        bus_write(A_STATUS, 32'h0001_0000);
        m_clip = 1'b0;
        check_status("clip_w1c");

        // Mute then unmute ch1.
        for (int i = 0; i < N_CH; i++) set_vol(i, 5'd0);
        set_vol(1, 5'h1F);
        m_ch[1] = 8'h80;
        drive_ch();
        run_epoch(1, 3);
        check("mute_out", 32'(out), 32'd0);
        set_vol(1, 5'h0F);
        run_epoch(1, 0);
        check("unmute_out", 32'(out), 32'h780);

        // Abort partway through the second frame.
        set_vol(2, 5'd7);
        run_epoch(1, 5);

        // Bus: readback and unmapped index.
        set_vol(3, 5'h0A);
        bus_read(32'd12, d);
        check("vol3_readback", d, 32'h0000_000A);
        bus_write(32'd160, 32'hFFFF_FFFF);
        bus_read(32'd160, d);
        check("unmapped_read", d, 32'd0);
        bus_read(A_CTRL, d);
        check("ctrl_read", d, 32'(m_en));

        // Randomized epochs.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N_CH; i++) begin
                m_ch[i] = IN_W'($urandom);
                set_vol(i, {($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15))});
            end
            drive_ch();
            k = $urandom_range(0, N_CH - 1);
            bus_read(32'(k * 4), d);
            check("vol_rand_readback", d, {27'd0, m_vol[k]});
            run_epoch($urandom_range(0, 3), $urandom_range(0, 7));
        end

        // Reset mid-frame.
        set_vol(0, 5'd9);
        m_ch[0] = 8'h55;
        drive_ch();
        bus_write(A_CTRL, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        check("midreset_out", 32'(out), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_ready", 32'(ready), 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        bus_read(32'd0, d);
        check("midreset_vol0", d, 32'd0);
        check_status("midreset_status");
        bus_read(A_CTRL, d);
        check("midreset_ctrl", d, 32'd0);
        repeat (FRAME * 2) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
